// File: rtl/xbar_sched_rr.sv
// Round-robin crossbar scheduler: binds each output to one input FIFO for a whole
// packet of PKT_LEN words, and drains packets whose destination field is invalid.
module xbar_sched_rr #(
  parameter int NPORTS  = 3,
  parameter int DATA_W  = 8,
  parameter int DEST_W  = 2,
  parameter int PKT_LEN = 4,
  parameter int SEL_W   = $clog2(NPORTS + 1)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NPORTS*DATA_W-1:0]   data,
  input  logic [NPORTS-1:0]          empty,
  output logic [NPORTS-1:0]          rdreq,
  output logic [NPORTS-1:0]          en,
  output logic [NPORTS*SEL_W-1:0]    sel,
  output logic [15:0]                drop_cnt
);

  localparam int IDX_W  = $clog2(NPORTS);
  localparam int CNT_W  = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam int DCNT_W = $clog2(NPORTS + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PKT_LEN - 1);

  typedef enum logic [1:0] {IN_IDLE, IN_BOUND, IN_DROP} in_st_t;

  in_st_t             r_in_st  [NPORTS];
  logic [CNT_W-1:0]   r_in_cnt [NPORTS];
  logic [NPORTS-1:0]  r_out_busy;
  logic [IDX_W-1:0]   r_out_own [NPORTS];
  logic [CNT_W-1:0]   r_out_cnt [NPORTS];
  logic [IDX_W-1:0]   r_rr      [NPORTS];
  logic [15:0]        r_drop_cnt;

  logic [DEST_W-1:0]  w_dest    [NPORTS];
  logic [NPORTS-1:0]  w_dest_ok;
  logic [NPORTS-1:0]  w_out_pop;
  logic [NPORTS-1:0]  w_gnt_vld;
  logic [IDX_W-1:0]   w_gnt_idx [NPORTS];
  logic [NPORTS-1:0]  w_in_gnt;
  logic [NPORTS-1:0]  w_in_rel;
  logic [NPORTS-1:0]  w_new_drop;
  logic [DCNT_W-1:0]  w_n_drop;
  logic               w_data_unused;

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [DCNT_W-1:0] b);
    logic [16:0] s;
    s = {1'b0, a} + 17'(b);
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  // Only the destination field of each head word matters to scheduling.
  assign w_data_unused = ^data;
  assign drop_cnt      = r_drop_cnt;

  always_comb begin
    for (int i = 0; i < NPORTS; i++) begin
      w_dest[i]    = data[i*DATA_W +: DEST_W];
      w_dest_ok[i] = (w_dest[i] != '0) && (w_dest[i] <= DEST_W'(NPORTS));
    end
  end

  // Transfer: pure function of registered ownership and the live empty flags.
  always_comb begin
    rdreq     = '0;
    en        = '0;
    sel       = '0;
    w_out_pop = '0;
    for (int o = 0; o < NPORTS; o++) begin
      if (r_out_busy[o]) begin
        w_out_pop[o]              = !empty[r_out_own[o]];
        en[o]                     = w_out_pop[o];
        rdreq[r_out_own[o]]       = w_out_pop[o];
        sel[o*SEL_W +: SEL_W]     = SEL_W'(r_out_own[o]) + SEL_W'(1);
      end
    end
    for (int i = 0; i < NPORTS; i++) begin
      if (r_in_st[i] == IN_DROP) rdreq[i] = !empty[i];
    end
  end

  // Arbitration never looks at rdreq, so there is no loop through the FIFOs.
  always_comb begin
    int c;
    c = 0;
    for (int o = 0; o < NPORTS; o++) begin
      w_gnt_vld[o] = 1'b0;
      w_gnt_idx[o] = '0;
      if (!r_out_busy[o]) begin
        for (int k = 1; k <= NPORTS; k++) begin
          c = int'(r_rr[o]) + k;
          if (c >= NPORTS) c = c - NPORTS;
          if (!w_gnt_vld[o] && r_in_st[c] == IN_IDLE && !empty[c] && w_dest_ok[c] &&
              (int'(w_dest[c]) - 1 == o)) begin
            w_gnt_vld[o] = 1'b1;
            w_gnt_idx[o] = IDX_W'(c);
          end
        end
      end
    end
  end

  always_comb begin
    w_in_gnt = '0;
    w_in_rel = '0;
    w_n_drop = '0;
    for (int o = 0; o < NPORTS; o++) begin
      if (w_gnt_vld[o]) w_in_gnt[w_gnt_idx[o]] = 1'b1;
      if (w_out_pop[o] && r_out_cnt[o] == LAST) w_in_rel[r_out_own[o]] = 1'b1;
    end
    for (int i = 0; i < NPORTS; i++) begin
      w_new_drop[i] = (r_in_st[i] == IN_IDLE) && !empty[i] && !w_dest_ok[i];
      w_n_drop      = w_n_drop + DCNT_W'(w_new_drop[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_busy <= '0;
      r_drop_cnt <= '0;
      for (int i = 0; i < NPORTS; i++) begin
        r_in_st[i]   <= IN_IDLE;
        r_in_cnt[i]  <= '0;
        r_out_own[i] <= '0;
        r_out_cnt[i] <= '0;
        r_rr[i]      <= IDX_W'(NPORTS - 1);
      end
    end else begin
      for (int o = 0; o < NPORTS; o++) begin
        if (r_out_busy[o]) begin
          if (w_out_pop[o]) begin
            if (r_out_cnt[o] == LAST) begin
              r_out_busy[o] <= 1'b0;
              r_out_cnt[o]  <= '0;
            end else begin
              r_out_cnt[o]  <= r_out_cnt[o] + 1'b1;
            end
          end
        end else if (w_gnt_vld[o]) begin
          r_out_busy[o] <= 1'b1;
          r_out_own[o]  <= w_gnt_idx[o];
          r_out_cnt[o]  <= '0;
          r_rr[o]       <= w_gnt_idx[o];
        end
      end
      for (int i = 0; i < NPORTS; i++) begin
        case (r_in_st[i])
          IN_IDLE: begin
            if (w_in_gnt[i]) begin
              r_in_st[i] <= IN_BOUND;
            end else if (w_new_drop[i]) begin
              r_in_st[i]  <= IN_DROP;
              r_in_cnt[i] <= '0;
            end
          end
          IN_BOUND: begin
            if (w_in_rel[i]) r_in_st[i] <= IN_IDLE;
          end
          IN_DROP: begin
            if (!empty[i]) begin
              if (r_in_cnt[i] == LAST) begin
                r_in_st[i]  <= IN_IDLE;
                r_in_cnt[i] <= '0;
              end else begin
                r_in_cnt[i] <= r_in_cnt[i] + 1'b1;
              end
            end
          end
          default: r_in_st[i] <= IN_IDLE;
        endcase
      end
      r_drop_cnt <= sat_add16(r_drop_cnt, w_n_drop);
    end
  end

endmodule

// File: tb/tb_xbar_sched_rr.sv
// Bench for xbar_sched_rr: FIFO queues plus a packet-level scheduler model,
// directed plan scenarios followed by random traffic.
module tb_xbar_sched_rr;
  localparam int NP = 3;
  localparam int DW = 8;
  localparam int DEST_W = 2;
  localparam int PL = 4;
  localparam int SW = $clog2(NP + 1);
  localparam int QD = 2048;

  logic clk = 1'b0;
  logic rst_n;
  logic [NP*DW-1:0] data;
  logic [NP-1:0] empty;
  logic [NP-1:0] rdreq;
  logic [NP-1:0] en;
  logic [NP*SW-1:0] sel;
  logic [15:0] drop_cnt;

  always #5 clk = ~clk;

  xbar_sched_rr #(.NPORTS(NP), .DATA_W(DW), .DEST_W(DEST_W), .PKT_LEN(PL), .SEL_W(SW)) dut (
    .clk(clk), .rst_n(rst_n), .data(data), .empty(empty),
    .rdreq(rdreq), .en(en), .sel(sel), .drop_cnt(drop_cnt)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [DW-1:0] fmem [NP][0:QD-1];
  int rp [NP];
  int wp [NP];

  // model: output owner (-1 = idle) and words left, rr = last winner,
  // input state 0 idle / 1 bound / 2 dropping
  int m_own [NP];
  int m_left [NP];
  int m_rr [NP];
  int m_in [NP];
  int m_dleft [NP];
  int m_drop;

  int n_en [NP];
  int n_stall1, n_droppop, n_all3, n_seq0;
  int seq0 [0:31];
  logic [SW-1:0] prev_sel0;
  int gen_left [NP];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  function automatic bit ne(int i);
    return rp[i] != wp[i];
  endfunction

  function automatic int hd(int i);
    logic [DW-1:0] w;
    w = fmem[i][rp[i] % QD];
    return int'(w[DEST_W-1:0]);
  endfunction

  task automatic drive();
    for (int i = 0; i < NP; i++) begin
      empty[i] = !ne(i);
      data[i*DW +: DW] = ne(i) ? fmem[i][rp[i] % QD] : DW'($urandom);
    end
  endtask

  task automatic push(input int i, input logic [DW-1:0] w);
    fmem[i][wp[i] % QD] = w;
    wp[i]++;
  endtask

  function automatic logic [DW-1:0] hdr(input int dest);
    logic [DW-1:0] h;
    h = DW'($urandom);
    h[DEST_W-1:0] = DEST_W'(dest);
    return h;
  endfunction

  task automatic push_pkt(input int i, input int dest);
    push(i, hdr(dest));
    for (int k = 1; k < PL; k++) push(i, DW'($urandom));
  endtask

  task automatic model_reset();
    for (int i = 0; i < NP; i++) begin
      m_own[i] = -1; m_left[i] = 0; m_rr[i] = NP - 1; m_in[i] = 0; m_dleft[i] = 0;
    end
    m_drop = 0;
  endtask

  task automatic clear_obs();
    for (int i = 0; i < NP; i++) n_en[i] = 0;
    n_stall1 = 0; n_droppop = 0; n_all3 = 0; n_seq0 = 0; prev_sel0 = '0;
  endtask

  // Advance the model across one rising edge using the pre-edge picture.
  task automatic model_step();
    int o_own [NP];
    int o_in [NP];
    int c;
    for (int i = 0; i < NP; i++) begin o_own[i] = m_own[i]; o_in[i] = m_in[i]; end
    for (int o = 0; o < NP; o++) begin
      if (o_own[o] >= 0 && ne(o_own[o])) begin
        m_left[o]--;
        if (m_left[o] == 0) begin m_in[o_own[o]] = 0; m_own[o] = -1; end
      end
    end
    for (int i = 0; i < NP; i++) begin
      if (o_in[i] == 2 && ne(i)) begin
        m_dleft[i]--;
        if (m_dleft[i] == 0) m_in[i] = 0;
      end
    end
    for (int o = 0; o < NP; o++) begin
      if (o_own[o] < 0) begin
        for (int k = 1; k <= NP; k++) begin
          c = (m_rr[o] + k) % NP;
          if (o_in[c] == 0 && ne(c) && hd(c) == o + 1) begin
            m_own[o] = c; m_left[o] = PL; m_rr[o] = c; m_in[c] = 1;
            break;
          end
        end
      end
    end
    for (int i = 0; i < NP; i++) begin
      if (o_in[i] == 0 && ne(i) && (hd(i) < 1 || hd(i) > NP)) begin
        m_in[i] = 2; m_dleft[i] = PL;
        if (m_drop < 65535) m_drop++;
      end
    end
  endtask

  task automatic cycle();
    logic [NP-1:0] e_rd, e_en;
    logic [NP*SW-1:0] e_sel;
    logic [SW-1:0] s0;
    @(negedge clk);
    e_rd = '0; e_en = '0; e_sel = '0;
    if (rst_n) begin
      for (int o = 0; o < NP; o++) begin
        if (m_own[o] >= 0) begin
          e_sel[o*SW +: SW] = SW'(m_own[o] + 1);
          if (ne(m_own[o])) begin e_rd[m_own[o]] = 1'b1; e_en[o] = 1'b1; end
        end
      end
      for (int i = 0; i < NP; i++) if (m_in[i] == 2 && ne(i)) e_rd[i] = 1'b1;
    end
    chk("rdreq", 32'(rdreq), 32'(e_rd));
    chk("en", 32'(en), 32'(e_en));
    chk("sel", 32'(sel), 32'(e_sel));
    chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
    for (int o = 0; o < NP; o++) if (en[o]) n_en[o]++;
    if (sel[SW +: SW] != '0 && !en[1]) n_stall1++;
    if (rdreq[1] && en == '0) n_droppop++;
    if (en == '1 && sel == {2'd1, 2'd3, 2'd2}) n_all3++;
    s0 = sel[0 +: SW];
    if (s0 != '0 && prev_sel0 == '0 && n_seq0 < 32) begin seq0[n_seq0] = int'(s0); n_seq0++; end
    prev_sel0 = s0;
    if (rst_n) model_step();
    @(posedge clk);
    #1;
    if (rst_n) for (int i = 0; i < NP; i++) if (e_rd[i]) rp[i]++;
    drive();
  endtask

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < NP; i++) begin rp[i] = 0; wp[i] = 0; gen_left[i] = 0; end
    model_reset();
    clear_obs();
    drive();
    // reset holds everything quiet even with a packet waiting
    push_pkt(0, 2);
    drive();
    repeat (3) cycle();
    chk("reset_drop_cnt", 32'(drop_cnt), 32'd0);
    rst_n = 1'b1;

    // single packet in0 -> output 1
    clear_obs();
    repeat (7) cycle();
    chk("single_en1", n_en[1], 4);
    chk("single_en0", n_en[0], 0);
    chk("single_en2", n_en[2], 0);

    // all inputs to output 0: rotation with one idle cycle between bursts
    clear_obs();
    for (int r = 0; r < 3; r++) for (int i = 0; i < NP; i++) push_pkt(i, 1);
    drive();
    repeat (48) cycle();
    chk("rr_en0", n_en[0], 36);
    chk("rr_bursts", n_seq0, 9);
    chk("rr_seq0", seq0[0], 1);
    chk("rr_seq1", seq0[1], 2);
    chk("rr_seq2", seq0[2], 3);
    chk("rr_seq3", seq0[3], 1);

    // parallel transfers on all outputs
    clear_obs();
    push_pkt(0, 3); push_pkt(1, 1); push_pkt(2, 2);
    drive();
    repeat (7) cycle();
    chk("parallel_cycles", n_all3, 4);

    // underrun after two words
    clear_obs();
    push(0, hdr(2)); push(0, DW'($urandom));
    drive();
    repeat (6) cycle();
    push(0, DW'($urandom)); push(0, DW'($urandom));
    drive();
    repeat (4) cycle();
    chk("underrun_stall", n_stall1, 3);
    chk("underrun_en1", n_en[1], 4);

    // invalid dest drained, then a good packet
    clear_obs();
    push_pkt(1, 0); push_pkt(1, 3);
    drive();
    repeat (12) cycle();
    chk("drop_pops", n_droppop, 4);
    chk("drop_cnt_after", 32'(drop_cnt), 32'd1);
    chk("drop_next_en2", n_en[2], 4);

    // asynchronous reset in the middle of a packet
    push_pkt(2, 1);
    drive();
    repeat (3) cycle();
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rdreq", 32'(rdreq), 32'd0);
    chk("async_en", 32'(en), 32'd0);
    chk("async_sel", 32'(sel), 32'd0);
    chk("async_drop_cnt", 32'(drop_cnt), 32'd0);
    model_reset();
    for (int i = 0; i < NP; i++) rp[i] = wp[i];
    for (int i = 0; i < NP; i++) push_pkt(i, 1);
    drive();
    repeat (2) cycle();
    rst_n = 1'b1;
    clear_obs();
    repeat (16) cycle();
    chk("post_reset_first", seq0[0], 1);

    // random traffic with partial packets and occasional bad destinations
    for (int n = 0; n < 900; n++) begin
      for (int i = 0; i < NP; i++) begin
        if (gen_left[i] == 0) begin
          if (n < 800 && $urandom_range(0, 3) == 0) begin
            int r;
            r = int'($urandom_range(0, 9));
            push(i, hdr(r == 0 ? 0 : 1 + (r % 3)));
            gen_left[i] = PL - 1;
          end
        end else if ($urandom_range(0, 2) != 0) begin
          push(i, DW'($urandom));
          gen_left[i]--;
        end
      end
      drive();
      cycle();
    end
    repeat (60) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/xbar_sched_rr.md
Name: xbar_sched_rr

Overview:
- Parametrised packet scheduler for the switch crossbar, replacing the fixed 3-port scheduler.
- Sits between the N per-input show-ahead FIFOs and the crossbar mux / output RAM enables.
- Reads the destination field of each FIFO's head word and round-robin arbitrates every output port among the contending inputs.
- Holds each grant for a whole packet of PKT_LEN words, tolerates FIFO underrun mid-packet, and drains packets with invalid destinations while counting them.

Parameters:
- NPORTS, 3, number of input FIFOs and number of output ports (2..8).
- DATA_W, 8, FIFO word width.
- DEST_W, 2, width of destination field in header bits [DEST_W-1:0]; must satisfy 2**DEST_W > NPORTS.
- PKT_LEN, 4, words per packet including header (1..256).
- SEL_W, $clog2(NPORTS+1), derived; width of each select field.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- data  in  NPORTS*DATA_W  head word of FIFO i at [i*DATA_W +: DATA_W]; valid when empty[i]=0.
- empty  in  NPORTS  FIFO i empty flag.
- rdreq  out  NPORTS  pop FIFO i this cycle (show-ahead; word popped at rising edge).
- en  out  NPORTS  output port o receives a word this cycle.
- sel  out  NPORTS*SEL_W  output o source: 0 = none, k = input k-1; field [o*SEL_W +: SEL_W].
- drop_cnt  out  16  count of dropped packets, saturating at 16'hFFFF.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (async assert, sync release by external reset logic): all outputs/inputs IDLE, word counters 0, rr pointer per output = NPORTS-1 (input 0 highest priority first), drop_cnt 0.
- rdreq, en and sel are 0 throughout reset.
- Reset mid-packet abandons the transfer; FIFO contents are untouched. Recovery of the partial packet is the upstream block's responsibility.
- Destination decode on head word h of FIFO i: d = h[DEST_W-1:0].
  - 1..NPORTS: valid, targets output d-1.
  - 0 or >NPORTS: invalid.
- Per-input state: IDLE, BOUND (owned by an output), DROP.
- Per-output state: IDLE, BUSY(owner, cnt).
- Arbitration (registered, evaluated every cycle):
  - Each IDLE output o considers IDLE inputs with empty=0 and valid d-1=o.
  - The winner is the first candidate scanning from rr[o]+1 upward modulo NPORTS.
  - At the edge: o goes BUSY(owner=winner, cnt=0), the input goes BOUND, and rr[o]=winner.
  - All outputs arbitrate independently in the same cycle; an input targets only one output, so there are no conflicts.
- Drop: an IDLE input with empty=0 and an invalid dest enters DROP at the edge; drop_cnt increments at that same edge (saturating).
- Transfer, combinational from registered state:
  - For BUSY o: rdreq[owner] = en[o] = !empty[owner]; sel[o] = owner+1.
  - For DROP input i: rdreq[i] = !empty[i], and no en.
  - Otherwise all outputs are 0; sel = 0 when IDLE even if a stall occurs.
- Counting and release:
  - cnt increments on each pop.
  - On the pop with cnt = PKT_LEN-1, the output and input return to IDLE at that edge (DROP likewise uses its own counter).
  - Underrun (empty=1 while BUSY/DROP) stalls: no pop, no count, grant held.
- Latency:
  - Header visible at cycle t with both sides IDLE: grant at edge t, first rdreq/en in cycle t+1.
  - Back-to-back packets on one output have exactly one idle cycle between them (release edge, then arbitrate).
- The arbitration/grant path never combinationally depends on rdreq; no combinational loop through the FIFOs.

Test Plan:
- Reset then NPORTS=3, PKT_LEN=4, FIFO0 head dest=2 (4 words), others empty: grant at edge 0; cycles 1-4 rdreq=001, en=010, sel[1]=1, and other sel fields stay 0; cycle 5 all zero.
- All three FIFOs hold continuous dest=1 packets: output 0 serves inputs 0,1,2,0,... (sel[0]=1,2,3,1); each burst is 4 cycles, with 1 idle cycle between bursts.
- Parallel: in0→dest3, in1→dest1, in2→dest2 simultaneously: all three en high in the same cycles, sel={1,3,2} for outputs {2,0,1} (sel[0]=2, sel[1]=3, sel[2]=1), with 4 transfer cycles.
- Underrun: FIFO0 empties after 2 words of a packet for 3 cycles: rdreq/en low for 3 cycles, sel held; the remaining 2 words complete, and release follows after the 4th pop.
- Invalid dest=0 on FIFO1, then dest=3: rdreq[1] high 4 cycles with en=000; drop_cnt 0→1; next packet granted to output 2.
- Async rst_n pulse mid-packet (between clock edges): outputs clear immediately, drop_cnt=0; after release input 0 wins first (rr pointer = NPORTS-1).
